// File: rtl/mem_arb_pkg.sv
// Shared sizing, FSM state and request-beat types for the memory request arbiter.
package mem_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int TAG_W  = $clog2(N_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the requestor after last_grant has top priority.
module rr_arbiter
    import mem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [TAG_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [TAG_W-1:0] grant_idx
);

    logic             found;
    logic [TAG_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = TAG_W'((int'(last_grant) + k) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Serialises four requestor streams onto one registered memory request slot with
// round-robin burst-locked arbitration, and routes memory responses back by tag.
module mem_req_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              io_requestor_0_req_valid,
    output logic              io_requestor_0_req_ready,
    input  logic [ADDR_W-1:0] io_requestor_0_req_bits_addr,
    input  logic [DATA_W-1:0] io_requestor_0_req_bits_data,
    input  logic [LEN_W-1:0]  io_requestor_0_req_bits_len,
    output logic              io_requestor_0_resp_valid,
    output logic [DATA_W-1:0] io_requestor_0_resp_bits_data,

    input  logic              io_requestor_1_req_valid,
    output logic              io_requestor_1_req_ready,
    input  logic [ADDR_W-1:0] io_requestor_1_req_bits_addr,
    input  logic [DATA_W-1:0] io_requestor_1_req_bits_data,
    input  logic [LEN_W-1:0]  io_requestor_1_req_bits_len,
    output logic              io_requestor_1_resp_valid,
    output logic [DATA_W-1:0] io_requestor_1_resp_bits_data,

    input  logic              io_requestor_2_req_valid,
    output logic              io_requestor_2_req_ready,
    input  logic [ADDR_W-1:0] io_requestor_2_req_bits_addr,
    input  logic [DATA_W-1:0] io_requestor_2_req_bits_data,
    input  logic [LEN_W-1:0]  io_requestor_2_req_bits_len,
    output logic              io_requestor_2_resp_valid,
    output logic [DATA_W-1:0] io_requestor_2_resp_bits_data,

    input  logic              io_requestor_3_req_valid,
    output logic              io_requestor_3_req_ready,
    input  logic [ADDR_W-1:0] io_requestor_3_req_bits_addr,
    input  logic [DATA_W-1:0] io_requestor_3_req_bits_data,
    input  logic [LEN_W-1:0]  io_requestor_3_req_bits_len,
    output logic              io_requestor_3_resp_valid,
    output logic [DATA_W-1:0] io_requestor_3_resp_bits_data,

    output logic              io_mem_req_valid,
    input  logic              io_mem_req_ready,
    output logic [ADDR_W-1:0] io_mem_req_bits_addr,
    output logic [DATA_W-1:0] io_mem_req_bits_data,
    output logic [TAG_W-1:0]  io_mem_req_bits_tag,
    input  logic              io_mem_resp_valid,
    input  logic [TAG_W-1:0]  io_mem_resp_bits_tag,
    input  logic [DATA_W-1:0] io_mem_resp_bits_data
);

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] resp_valid;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] arb_grant;
    mem_req_t         req_bits [N_REQ];
    mem_req_t         sel_bits;
    logic [TAG_W-1:0] arb_idx;
    logic [TAG_W-1:0] sel_idx;
    logic             slot_free;
    logic             accept;

    arb_state_t        state_reg;
    logic [TAG_W-1:0]  last_grant_reg;
    logic [TAG_W-1:0]  owner_reg;
    logic [LEN_W-1:0]  count_reg;
    logic              out_valid_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [TAG_W-1:0]  out_tag_reg;

    assign req_valid = {io_requestor_3_req_valid, io_requestor_2_req_valid,
                        io_requestor_1_req_valid, io_requestor_0_req_valid};

    assign req_bits[0] = '{addr: io_requestor_0_req_bits_addr, data: io_requestor_0_req_bits_data,
                           len: io_requestor_0_req_bits_len};
    assign req_bits[1] = '{addr: io_requestor_1_req_bits_addr, data: io_requestor_1_req_bits_data,
                           len: io_requestor_1_req_bits_len};
    assign req_bits[2] = '{addr: io_requestor_2_req_bits_addr, data: io_requestor_2_req_bits_data,
                           len: io_requestor_2_req_bits_len};
    assign req_bits[3] = '{addr: io_requestor_3_req_bits_addr, data: io_requestor_3_req_bits_data,
                           len: io_requestor_3_req_bits_len};

    rr_arbiter u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    // While a burst is locked, the arbiter result is ignored and only the owner is eligible.
    assign slot_free = !out_valid_reg || io_mem_req_ready;
    assign grant     = (state_reg == BURST) ? (N_REQ'(1) << owner_reg) : arb_grant;
    assign sel_idx   = (state_reg == BURST) ? owner_reg : arb_idx;
    assign sel_bits  = req_bits[sel_idx];
    assign accept    = |(req_ready & req_valid);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
        assign req_ready[gi]  = grant[gi] && slot_free && reset;
        assign resp_valid[gi] = io_mem_resp_valid &&
                                ({1'b0, io_mem_resp_bits_tag} == (TAG_W+1)'(gi));
    end

    assign io_requestor_0_req_ready = req_ready[0];
    assign io_requestor_1_req_ready = req_ready[1];
    assign io_requestor_2_req_ready = req_ready[2];
    assign io_requestor_3_req_ready = req_ready[3];

    assign io_requestor_0_resp_valid = resp_valid[0];
    assign io_requestor_1_resp_valid = resp_valid[1];
    assign io_requestor_2_resp_valid = resp_valid[2];
    assign io_requestor_3_resp_valid = resp_valid[3];

    assign io_requestor_0_resp_bits_data = io_mem_resp_bits_data;
    assign io_requestor_1_resp_bits_data = io_mem_resp_bits_data;
    assign io_requestor_2_resp_bits_data = io_mem_resp_bits_data;
    assign io_requestor_3_resp_bits_data = io_mem_resp_bits_data;

    assign io_mem_req_valid     = out_valid_reg;
    assign io_mem_req_bits_addr = out_addr_reg;
    assign io_mem_req_bits_data = out_data_reg;
    assign io_mem_req_bits_tag  = out_tag_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= TAG_W'(N_REQ - 1);
            owner_reg      <= '0;
            count_reg      <= '0;
            out_valid_reg  <= 1'b0;
            out_addr_reg   <= '0;
            out_data_reg   <= '0;
            out_tag_reg    <= '0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_addr_reg  <= sel_bits.addr;
                out_data_reg  <= sel_bits.data;
                out_tag_reg   <= sel_idx;
            end else if (io_mem_req_ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        last_grant_reg <= arb_idx;
                        if (sel_bits.len != '0) begin
                            state_reg <= BURST;
                            count_reg <= sel_bits.len;
                            owner_reg <= arb_idx;
                        end
                    end
                end
                BURST: begin
                    // count holds the beats still owed; the beat taken at count==1 ends the lock.
                    if (accept) begin
                        count_reg <= count_reg - LEN_W'(1);
                        if (count_reg == LEN_W'(1)) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
